// File: rtl/spi_slave.sv
// SPI slave endpoint, all four CPOL/CPHA modes, oversampled on clk.
// Bus inputs are synchronized and edge-detected; data moves through tx holding and rx output registers.
//
// state  | meaning
// IDLE   | cs_n high (or awaiting a fresh cs_n fall after reset); MISO not driven
// ACTIVE | frame in progress; counting sampling edges, shifting MOSI/MISO
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             underrun,
  output logic             frame_err,
  input  logic             spi_clk,
  input  logic             spi_data_in,
  input  logic             cs_n,
  output logic             spi_data_out,
  output logic             spi_data_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [1:0]       mode_q;
  logic [2:0]       sclk_sync;
  logic [2:0]       cs_sync;
  logic [1:0]       mosi_sync;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] tx_sr;
  logic             dout;
  logic             ur_pend;
  logic [WIDTH-1:0] rx_sr;

  // Synchronizers free-run through reset so a cs_n already low at release is not seen as an edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[1:0], spi_clk};
    cs_sync   <= {cs_sync[1:0], cs_n};
    mosi_sync <= {mosi_sync[0], spi_data_in};
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, active;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic entry, wrap, word_start, load_cpha, tx_load, word_empty;
  logic [WIDTH-1:0] next_word, rx_word;

  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall     = ~cs_sync[1] & cs_sync[2];
  assign cs_rise     = cs_sync[1] & ~cs_sync[2];
  assign active      = (state == ACTIVE);

  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = active & ~cs_rise & (mode_q[0] ? trail_edge : lead_edge);
  // In cpha=0 the trailing edge right after a word's last sample must not shift the freshly loaded MSB.
  assign shift_edge  = active & ~cs_rise &
                       (mode_q[0] ? lead_edge : (trail_edge & (bit_cnt != '0)));

  assign entry       = ~active & cs_fall;
  assign wrap        = sample_edge & (bit_cnt == LAST);
  assign word_start  = entry | wrap;
  assign load_cpha   = entry ? mode[0] : mode_q[0];

  assign tx_ready    = ~hold_full;
  assign tx_load     = tx_valid & tx_ready;
  assign next_word   = hold_full ? hold_data : (tx_load ? tx_data : '0);
  assign word_empty  = ~hold_full & ~tx_load;
  assign rx_word     = {rx_sr[WIDTH-2:0], mosi_sync[1]};

  assign spi_data_oe  = active;
  assign spi_data_out = active & dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      mode_q    <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (entry) begin
        state   <= ACTIVE;
        mode_q  <= mode;
        bit_cnt <= '0;
      end else if (active && cs_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        frame_err <= (bit_cnt != '0);
      end else if (sample_edge) begin
        bit_cnt <= wrap ? '0 : bit_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      tx_sr     <= '0;
      dout      <= 1'b0;
      underrun  <= 1'b0;
      ur_pend   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (word_start) begin
        hold_full <= 1'b0;
        tx_sr     <= load_cpha ? next_word : (next_word << 1);
        if (!load_cpha)
          dout <= next_word[WIDTH-1];
        // A wrap-time underrun only counts once the master actually clocks the next word.
        if (entry)
          underrun <= word_empty;
        else
          ur_pend  <= word_empty;
      end else if (tx_load) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (shift_edge) begin
        dout  <= tx_sr[WIDTH-1];
        tx_sr <= tx_sr << 1;
      end
      if (sample_edge && bit_cnt == '0 && ur_pend) begin
        underrun <= 1'b1;
        ur_pend  <= 1'b0;
      end
      if (active && cs_rise) begin
        dout    <= 1'b0;
        ur_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (sample_edge)
        rx_sr <= rx_word;
      if (wrap) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master with hand-computed expected words.
// Pulse outputs are tallied continuously; tests compare tally deltas.
module tb_spi_slave;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       overrun, underrun, frame_err;
  logic       spi_clk, spi_data_in, cs_n, spi_data_out, spi_data_oe;

  int n_chk = 0;
  int n_err = 0;
  int ov_cnt = 0, ur_cnt = 0, fe_cnt = 0, rxv_rise = 0;
  logic rxv_prev = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .underrun(underrun), .frame_err(frame_err),
    .spi_clk(spi_clk), .spi_data_in(spi_data_in), .cs_n(cs_n),
    .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe)
  );

  always @(negedge clk) begin
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (underrun)  ur_cnt <= ur_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_valid && !rxv_prev) rxv_rise <= rxv_rise + 1;
    rxv_prev <= rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 100) begin
      wait_clks(1);
      t++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_assert(input logic [1:0] m);
    mode    = m;
    spi_clk = m[1];
    wait_clks(HALF);
    cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_deassert();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic spi_bits(input logic [1:0] m, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        spi_data_in = mo[7-i];
        wait_clks(HALF);
        spi_clk = ~m[1];
        mi = {mi[6:0], spi_data_out};
        wait_clks(HALF);
        spi_clk = m[1];
      end else begin
        spi_clk = ~m[1];
        spi_data_in = mo[7-i];
        wait_clks(HALF);
        spi_clk = m[1];
        mi = {mi[6:0], spi_data_out};
        wait_clks(HALF);
      end
    end
  endtask

  task automatic rx_take(input logic [7:0] exp, input string tag);
    chk({tag, "_rxv"}, 32'(rx_valid), 32'd1);
    chk({tag, "_rxd"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    chk({tag, "_rxclr"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int s_ov, s_ur, s_fe, s_rx;

    rst = 1'b1; mode = 2'b00; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    spi_clk = 1'b0; spi_data_in = 1'b0; cs_n = 1'b1;
    wait_clks(4);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data), 32'd0);
    chk("rst_oe_out",   32'({spi_data_oe, spi_data_out}), 32'd0);
    chk("rst_pulses",   32'({overrun, underrun, frame_err}), 32'd0);
    rst = 1'b0;
    wait_clks(2);

    // mode 0 basic word
    s_ur = ur_cnt; s_rx = rxv_rise;
    tx_load(8'hA5);
    cs_assert(2'b00);
    chk("m0_oe", 32'(spi_data_oe), 32'd1);
    spi_bits(2'b00, 8'h3C, 8, mi);
    cs_deassert();
    chk("m0_miso", 32'(mi), 32'hA5);
    chk("m0_rx_rise", 32'(rxv_rise - s_rx), 32'd1);
    chk("m0_underrun", 32'(ur_cnt - s_ur), 32'd0);
    chk("m0_oe_idle", 32'({spi_data_oe, spi_data_out}), 32'd0);
    rx_take(8'h3C, "m0");

    for (int m = 1; m < 4; m++) begin
      tx_load(8'h81);
      cs_assert(2'(m));
      spi_bits(2'(m), 8'h7E, 8, mi);
      cs_deassert();
      chk($sformatf("m%0d_miso", m), 32'(mi), 32'h81);
      rx_take(8'h7E, $sformatf("m%0d", m));
    end

    // mode input changed mid-frame must not affect the frame
    tx_load(8'h96);
    cs_assert(2'b00);
    mode = 2'b11;
    spi_bits(2'b00, 8'h69, 8, mi);
    cs_deassert();
    chk("mchg_miso", 32'(mi), 32'h96);
    rx_take(8'h69, "mchg");

    // two words back to back, consumer stalled
    s_ov = ov_cnt; s_ur = ur_cnt; s_rx = rxv_rise;
    tx_load(8'h11);
    cs_assert(2'b00);
    tx_load(8'h22);
    spi_bits(2'b00, 8'hA1, 8, mi);
    spi_bits(2'b00, 8'hB2, 8, mi2);
    cs_deassert();
    chk("w2_miso1", 32'(mi), 32'h11);
    chk("w2_miso2", 32'(mi2), 32'h22);
    chk("w2_overrun", 32'(ov_cnt - s_ov), 32'd1);
    chk("w2_underrun", 32'(ur_cnt - s_ur), 32'd0);
    chk("w2_rx_rise", 32'(rxv_rise - s_rx), 32'd1);
    rx_take(8'hA1, "w2");

    // empty holding register
    s_ur = ur_cnt;
    cs_assert(2'b00);
    spi_bits(2'b00, 8'h5A, 8, mi);
    cs_deassert();
    chk("ur_miso", 32'(mi), 32'h00);
    chk("ur_count", 32'(ur_cnt - s_ur), 32'd1);
    rx_take(8'h5A, "ur");

    // cs_n raised mid-word
    s_fe = fe_cnt; s_rx = rxv_rise;
    cs_assert(2'b00);
    spi_bits(2'b00, 8'hFF, 5, mi);
    cs_deassert();
    chk("fe_count", 32'(fe_cnt - s_fe), 32'd1);
    chk("fe_rx_valid", 32'(rx_valid), 32'd0);
    chk("fe_rx_rise", 32'(rxv_rise - s_rx), 32'd0);
    cs_assert(2'b00);
    spi_bits(2'b00, 8'h55, 8, mi);
    cs_deassert();
    rx_take(8'h55, "fe_next");
    chk("fe_count_after", 32'(fe_cnt - s_fe), 32'd1);

    // reset mid-frame with cs_n held low
    s_fe = fe_cnt; s_rx = rxv_rise;
    tx_load(8'hE7);
    cs_assert(2'b00);
    spi_bits(2'b00, 8'hF0, 3, mi);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
    chk("rr_oe", 32'({spi_data_oe, spi_data_out}), 32'd0);
    spi_bits(2'b00, 8'h0F, 8, mi);
    chk("rr_oe_clocked", 32'(spi_data_oe), 32'd0);
    chk("rr_rx_valid", 32'(rx_valid), 32'd0);
    cs_deassert();
    chk("rr_frame_err", 32'(fe_cnt - s_fe), 32'd0);
    chk("rr_rx_rise", 32'(rxv_rise - s_rx), 32'd0);
    tx_load(8'hC3);
    cs_assert(2'b00);
    chk("rr_oe_fresh", 32'(spi_data_oe), 32'd1);
    spi_bits(2'b00, 8'h3A, 8, mi);
    cs_deassert();
    chk("rr_miso", 32'(mi), 32'hC3);
    rx_take(8'h3A, "rr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per SPI word (MSB first).
REQ-002 SHALL have port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port mode  input  2  {cpol, cpha}; latched on detected cs_n falling edge.
REQ-005 SHALL have port tx_data  input  WIDTH  next word to return on MISO.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port tx_ready  output  1  holding register empty; load when tx_valid & tx_ready.
REQ-008 SHALL have port rx_data  output  WIDTH  last received word.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: received word dropped.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse: word started with empty tx holding register.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse: cs_n deasserted mid-word.
REQ-014 SHALL have ports spi_clk, spi_data_in (MOSI), cs_n  input  1 each  SPI bus from master.
REQ-015 SHALL have ports spi_data_out (MISO), spi_data_oe  output  1 each  MISO data and drive enable.

Function
REQ-016 SHALL synchronize spi_clk, cs_n, spi_data_in through 2 flops, then edge-detect on a third registered copy; spi_clk frequency SHALL be <= clk/8.
REQ-017 SHALL implement states IDLE (cs_n high) and ACTIVE; IDLE->ACTIVE on synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n rising edge.
REQ-018 Leading edge = rising if cpol=0, falling if cpol=1; trailing edge = the opposite.
REQ-019 cpha=0: sample MOSI on leading edge, shift MISO on trailing edge; first bit driven on MISO the cycle after cs_n falling edge detect.
REQ-020 cpha=1: shift MISO on leading edge (first leading edge drives MSB), sample MOSI on trailing edge.
REQ-021 Bit counter SHALL count sampling edges 0..WIDTH-1, wrap to 0 after WIDTH-1; consecutive words within one cs_n assertion are supported with no gap.
REQ-022 At each word start (ACTIVE entry, or counter wrap) the tx shift register SHALL load the holding register and set tx_ready=1 in the next cycle; if the holding register is empty, load all-zero and pulse underrun.
REQ-023 tx_valid & tx_ready SHALL load tx_data and clear tx_ready next cycle; a load coinciding with word start SHALL be used for that word.
REQ-024 On the WIDTH-th sampling edge, if rx_valid=0 or rx_ready=1 that cycle, rx_data SHALL update and rx_valid=1 one clk after the edge detect; otherwise the word SHALL be dropped, rx_data unchanged, overrun pulsed.
REQ-025 rx_valid & rx_ready with no new word SHALL clear rx_valid next cycle.
REQ-026 cs_n rising edge with bit counter != 0 SHALL pulse frame_err, discard the partial word, no rx_valid; counter reset to 0.
REQ-027 spi_data_oe SHALL be 1 only in ACTIVE; spi_data_out SHALL be 0 when spi_data_oe=0.
REQ-028 mode changes while ACTIVE SHALL be ignored until the next cs_n falling edge.
REQ-029 spi_clk edges while IDLE SHALL be ignored.

Reset
REQ-030 On rst=1 at a clk edge: state IDLE, counter 0, tx_ready=1, rx_valid=0, rx_data=0, overrun=underrun=frame_err=0, spi_data_out=0, spi_data_oe=0, holding register empty, mode latch=00.
REQ-031 Reset asserted mid-frame SHALL abort without frame_err; the block SHALL stay IDLE until a fresh cs_n falling edge, even if cs_n is low when rst releases.

Verification
REQ-032 Mode 0, tx 0xA5 loaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid pulse-to-handshake once.
REQ-033 Modes 1,2,3 each: tx 0x81, master sends 0x7E -> master reads 0x81, rx_data=0x7E.
REQ-034 Two words in one cs_n assertion, tx 0x11 then 0x22 loaded before the wrap, rx_ready held 0 -> second word dropped, overrun pulse once, rx_data=first word.
REQ-035 No tx load, master clocks 8 bits -> MISO all 0, underrun pulse once.
REQ-036 cs_n raised after 5 bits -> frame_err pulse, rx_valid stays 0; next full frame 0x55 received correctly.
REQ-037 rst pulsed after 3 bits with cs_n held low -> no rx_valid, spi_data_oe=0 until cs_n toggles high-low.
